// File: rtl/siphash_feeder.sv
// SipHash command sequencer: turns a key plus a byte stream into
// key-load, compress, length-pad and finalize commands for the core.
module siphash_feeder #(
   parameter int CNT_W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic         empty,
   input  logic [127:0] key,
   input  logic         s_valid,
   input  logic [7:0]   s_data,
   input  logic         s_last,
   output logic         s_ready,
   output logic         core_we,
   output logic [67:0]  core_cmd,
   input  logic         core_busy,
   input  logic [63:0]  core_result,
   output logic         ready_o,
   output logic         hash_valid,
   output logic [63:0]  hash
);

   typedef enum logic [3:0] {
      IDLE, KEY0, KEY1, COLLECT, COMP, CWAIT,
      PAD, PWAIT, FIN, FWAIT, DONE
   } state_t;

   localparam logic [3:0] OP_K0  = 4'h0;
   localparam logic [3:0] OP_K1  = 4'h1;
   localparam logic [3:0] OP_CMP = 4'h2;
   localparam logic [3:0] OP_FIN = 4'h3;

   state_t             state_q, state_d;
   logic [127:0]       key_q, key_d;
   logic               empty_q, empty_d;
   logic [63:0]        buf_q, buf_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               last_q, last_d;
   logic [67:0]        cmd_q, cmd_d;
   logic [63:0]        hash_q, hash_d;

   logic               issue;
   logic [67:0]        issue_cmd;
   logic [7:0]         len_b;
   logic [63:0]        pad_word;

   assign len_b    = 8'(cnt_q);
   assign pad_word = {len_b, 56'h0} | buf_q;

   always_comb begin
      state_d   = state_q;
      key_d     = key_q;
      empty_d   = empty_q;
      buf_d     = buf_q;
      cnt_d     = cnt_q;
      last_d    = last_q;
      hash_d    = hash_q;
      issue     = 1'b0;
      issue_cmd = cmd_q;
      s_ready   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               key_d   = key;
               empty_d = empty;
               cnt_d   = '0;
               buf_d   = '0;
               last_d  = 1'b0;
               state_d = KEY0;
            end
         end
         KEY0: begin
            issue     = 1'b1;
            issue_cmd = {OP_K0, key_q[63:0]};
            if (!core_busy) state_d = KEY1;
         end
         KEY1: begin
            issue     = 1'b1;
            issue_cmd = {OP_K1, key_q[127:64]};
            if (!core_busy) state_d = empty_q ? PAD : COLLECT;
         end
         COLLECT: begin
            s_ready = 1'b1;
            if (s_valid) begin
               buf_d[{cnt_q[2:0], 3'b000} +: 8] = s_data;
               cnt_d = cnt_q + 1'b1;
               // a full word compresses first; s_last is remembered for after
               if (cnt_q[2:0] == 3'd7) begin
                  last_d  = s_last;
                  state_d = COMP;
               end else if (s_last) begin
                  state_d = PAD;
               end
            end
         end
         COMP: begin
            issue     = 1'b1;
            issue_cmd = {OP_CMP, buf_q};
            if (!core_busy) state_d = CWAIT;
         end
         CWAIT: begin
            if (!core_busy) begin
               buf_d   = '0;
               state_d = last_q ? PAD : COLLECT;
            end
         end
         PAD: begin
            issue     = 1'b1;
            issue_cmd = {OP_CMP, pad_word};
            if (!core_busy) state_d = PWAIT;
         end
         PWAIT: begin
            if (!core_busy) state_d = FIN;
         end
         FIN: begin
            issue     = 1'b1;
            issue_cmd = {OP_FIN, 64'h0};
            if (!core_busy) state_d = FWAIT;
         end
         FWAIT: begin
            if (!core_busy) begin
               hash_d  = core_result;
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign core_we    = issue && !core_busy;
   assign cmd_d      = core_we ? issue_cmd : cmd_q;
   assign core_cmd   = cmd_d;
   assign ready_o    = (state_q == IDLE);
   assign hash_valid = (state_q == DONE);
   assign hash       = hash_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         key_q   <= '0;
         empty_q <= 1'b0;
         buf_q   <= '0;
         cnt_q   <= '0;
         last_q  <= 1'b0;
         cmd_q   <= '0;
         hash_q  <= '0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         empty_q <= empty_d;
         buf_q   <= buf_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         cmd_q   <= cmd_d;
         hash_q  <= hash_d;
      end
   end

endmodule

// File: tb/tb_siphash_feeder.sv
// Bench for siphash_feeder: behavioural SipHash-2-4 core plus a
// message-level reference for hashes and command order.
module tb_siphash_feeder;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start, empty, s_valid, s_last;
   logic [127:0] key;
   logic [7:0]   s_data;
   logic         s_ready, core_we, core_busy, ready_o, hash_valid;
   logic [67:0]  core_cmd;
   logic [63:0]  core_result, hash;

   always #5 clk = ~clk;

   siphash_feeder #(.CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .empty(empty), .key(key),
      .s_valid(s_valid), .s_data(s_data), .s_last(s_last),
      .s_ready(s_ready), .core_we(core_we), .core_cmd(core_cmd),
      .core_busy(core_busy), .core_result(core_result),
      .ready_o(ready_o), .hash_valid(hash_valid), .hash(hash)
   );

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [127:0] got,
                      input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rotl(input logic [63:0] x, input int n);
      return (x << n) | (x >> (64 - n));
   endfunction

   function automatic logic [255:0] sipround(input logic [255:0] s);
      logic [63:0] v0, v1, v2, v3;
      {v0, v1, v2, v3} = s;
      v0 += v1; v1 = rotl(v1, 13); v1 ^= v0; v0 = rotl(v0, 32);
      v2 += v3; v3 = rotl(v3, 16); v3 ^= v2;
      v0 += v3; v3 = rotl(v3, 21); v3 ^= v0;
      v2 += v1; v1 = rotl(v1, 17); v1 ^= v2; v2 = rotl(v2, 32);
      return {v0, v1, v2, v3};
   endfunction

   function automatic logic [255:0] sip_init(input logic [63:0] k0,
                                             input logic [63:0] k1);
      return {k0 ^ 64'h736f6d6570736575, k1 ^ 64'h646f72616e646f6d,
              k0 ^ 64'h6c7967656e657261, k1 ^ 64'h7465646279746573};
   endfunction

   function automatic logic [255:0] sip_comp(input logic [255:0] s,
                                             input logic [63:0] m);
      logic [255:0] t;
      t = s;
      t[63:0] ^= m;
      t = sipround(sipround(t));
      t[255:192] ^= m;
      return t;
   endfunction

   function automatic logic [63:0] sip_fin(input logic [255:0] s);
      logic [255:0] t;
      t = s;
      t[127:64] ^= 64'hff;
      for (int i = 0; i < 4; i++) t = sipround(t);
      return t[255:192] ^ t[191:128] ^ t[127:64] ^ t[63:0];
   endfunction

   // behavioural core: key loads are instant, compress/finalize take 1..4 busy cycles
   logic [63:0]  mk0;
   logic [255:0] cst;
   logic [67:0]  held;
   int           bcnt;
   int           we_busy_err = 0;
   int           unstable_err = 0;
   logic [67:0]  cmd_log[$];

   always @(posedge clk) begin
      if (!rst_n) begin
         core_busy <= 1'b0;
         bcnt      <= 0;
      end else begin
         if (core_busy) begin
            if (core_cmd !== held) unstable_err <= unstable_err + 1;
            if (bcnt == 0) begin
               core_busy <= 1'b0;
               if (held[67:64] == 4'h2) cst <= sip_comp(cst, core_cmd[63:0]);
               else core_result <= sip_fin(cst);
            end else begin
               bcnt <= bcnt - 1;
            end
         end
         if (core_we) begin
            if (core_busy) we_busy_err <= we_busy_err + 1;
            cmd_log.push_back(core_cmd);
            case (core_cmd[67:64])
               4'h0: mk0 <= core_cmd[63:0];
               4'h1: cst <= sip_init(mk0, core_cmd[63:0]);
               default: begin
                  held      <= core_cmd;
                  core_busy <= 1'b1;
                  bcnt      <= int'($urandom_range(3, 0));
               end
            endcase
         end
      end
   end

   int          hv_cnt = 0;
   int          acc_cnt = 0;
   logic [63:0] got_hash;

   always @(negedge clk) begin
      if (hash_valid) begin
         hv_cnt   <= hv_cnt + 1;
         got_hash <= hash;
      end
   end

   always @(posedge clk) if (s_valid && s_ready) acc_cnt <= acc_cnt + 1;

   logic [7:0]  msg[$];
   logic [67:0] expc[$];

   // expected command list and hash from the message bytes alone
   function automatic logic [63:0] build_ref(input logic [127:0] k);
      int n;
      logic [63:0] m;
      logic [255:0] s;
      n = msg.size();
      expc.delete();
      expc.push_back({4'h0, k[63:0]});
      expc.push_back({4'h1, k[127:64]});
      for (int w = 0; w < n / 8; w++) begin
         m = '0;
         for (int b = 0; b < 8; b++) m[8*b +: 8] = msg[8*w + b];
         expc.push_back({4'h2, m});
      end
      m = 64'(n % 256) << 56;
      for (int b = 0; b < n % 8; b++) m[8*b +: 8] = msg[(n / 8) * 8 + b];
      expc.push_back({4'h2, m});
      expc.push_back({4'h3, 64'h0});
      s = sip_init(k[63:0], k[127:64]);
      foreach (expc[i]) if (expc[i][67:64] == 4'h2) s = sip_comp(s, expc[i][63:0]);
      return sip_fin(s);
   endfunction

   task automatic do_hash(input logic [127:0] k, input bit throttle,
                          input bit xstart, output logic [63:0] res);
      int h0, a0, t, n;
      bit stuck;
      logic [63:0] exp_h;
      exp_h = build_ref(k);
      n = msg.size();
      s_valid = 1'b0;
      t = 0;
      while (!ready_o && t < 1000) begin @(posedge clk); #1; t++; end
      chk("ready_before_start", ready_o, 1'b1);
      cmd_log.delete();
      h0 = hv_cnt;
      a0 = acc_cnt;
      key = k;
      empty = (n == 0);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      key = {$urandom, $urandom, $urandom, $urandom};
      empty = ~empty;
      stuck = 1'b0;
      for (int i = 0; i < n && !stuck; i++) begin
         if (throttle) begin
            s_valid = 1'b0;
            repeat ($urandom_range(3, 0)) begin @(posedge clk); #1; end
         end
         s_valid = 1'b1;
         s_data = msg[i];
         s_last = (i == n - 1);
         if (xstart && i == 2) start = 1'b1;
         t = 0;
         do begin @(negedge clk); t++; end while (!s_ready && t < 1000);
         if (!s_ready) begin
            chk("byte_accept_timeout", 1'b0, 1'b1);
            stuck = 1'b1;
         end
         @(posedge clk); #1;
         start = 1'b0;
      end
      // a stray byte after s_last must not be taken
      s_valid = throttle;
      s_data = 8'ha5;
      s_last = 1'b1;
      t = 0;
      while (hv_cnt == h0 && t < 2000) begin @(posedge clk); #1; t++; end
      repeat (3) begin @(posedge clk); #1; end
      s_valid = 1'b0;
      chk("hash_pulses", hv_cnt - h0, 1);
      chk("hash", got_hash, exp_h);
      chk("bytes_taken", acc_cnt - a0, n);
      chk("cmd_count", cmd_log.size(), expc.size());
      for (int i = 0; i < expc.size() && i < cmd_log.size(); i++)
         chk($sformatf("cmd[%0d]", i), cmd_log[i], expc[i]);
      res = got_hash;
   endtask

   localparam logic [127:0] KREF = 128'h0f0e0d0c0b0a09080706050403020100;

   task automatic seq_msg(input int n);
      msg.delete();
      for (int i = 0; i < n; i++) msg.push_back(8'(i));
   endtask

   initial begin
      logic [63:0] r;
      logic [127:0] k;
      int t;
      int h0;
      rst_n = 1'b0;
      start = 1'b0; empty = 1'b0; key = '0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0;
      #12;
      chk("rst_ready", ready_o, 1'b1);
      chk("rst_sready", s_ready, 1'b0);
      chk("rst_we", core_we, 1'b0);
      chk("rst_cmd", core_cmd, 68'h0);
      chk("rst_hv", hash_valid, 1'b0);
      chk("rst_hash", hash, 64'h0);
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;

      seq_msg(0);  do_hash(KREF, 1'b0, 1'b0, r); chk("vec_empty", r, 64'h726fdb47dd0e0e31);
      seq_msg(1);  do_hash(KREF, 1'b0, 1'b0, r); chk("vec_1", r, 64'h74f839c593dc67fd);
      seq_msg(8);  do_hash(KREF, 1'b0, 1'b0, r); chk("vec_8", r, 64'h93f5f5799a932462);
      seq_msg(15); do_hash(KREF, 1'b0, 1'b0, r); chk("vec_15", r, 64'ha129ca6149be45e5);
      seq_msg(8);  do_hash(KREF, 1'b1, 1'b1, r); chk("thr_8", r, 64'h93f5f5799a932462);
      seq_msg(15); do_hash(KREF, 1'b1, 1'b1, r); chk("thr_15", r, 64'ha129ca6149be45e5);

      for (int j = 0; j < 6; j++) begin
         msg.delete();
         repeat ($urandom_range(20, 0)) msg.push_back(8'($urandom));
         k = {$urandom, $urandom, $urandom, $urandom};
         do_hash(k, j[0], j[1], r);
      end
      msg.delete();
      repeat (258) msg.push_back(8'($urandom));
      do_hash({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, r);

      // abort during a compress wait
      seq_msg(8);
      key = KREF; empty = 1'b0; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         s_valid = 1'b1; s_data = msg[i]; s_last = 1'b0;
         t = 0;
         do begin @(negedge clk); t++; end while (!s_ready && t < 100);
         @(posedge clk); #1;
      end
      s_valid = 1'b0;
      t = 0;
      do begin @(negedge clk); t++; end while (!core_busy && t < 100);
      chk("abort_in_cwait", core_busy, 1'b1);
      h0 = hv_cnt;
      #1 rst_n = 1'b0;
      #1;
      chk("abort_sready", s_ready, 1'b0);
      chk("abort_we", core_we, 1'b0);
      chk("abort_cmd", core_cmd, 68'h0);
      chk("abort_hv", hash_valid, 1'b0);
      chk("abort_hash", hash, 64'h0);
      chk("abort_ready", ready_o, 1'b1);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      chk("abort_no_hv", hv_cnt - h0, 0);
      chk("abort_ready_after", ready_o, 1'b1);
      seq_msg(0);  do_hash(KREF, 1'b0, 1'b0, r); chk("post_abort_empty", r, 64'h726fdb47dd0e0e31);

      chk("we_while_busy", we_busy_err, 0);
      chk("cmd_stable", unstable_err, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/siphash_feeder.md
Name: siphash_feeder

Overview:
- Upstream stage of the SipHash core. Takes a 128-bit key and a byte-serial message over a valid/ready stream.
- Drives the core's `we`/`cmd[67:0]` command port in order: key load, one compression per 8-byte word, length-padded final word, finalize.
- Returns the core's 64-bit result as a one-cycle-valid hash.
- Sole owner of the core command port; the core is instantiated alongside, not inside.

Parameters:
- CNT_W, 8: width of the internal message byte counter (≥3). Wraps mod 2^CNT_W. Only bits [7:0] enter the pad word.

Ports:
- clk  input  1  clock
- rst_n  input  1  reset, asynchronous assert, active-low
- start  input  1  pulse; begin a hash. Ignored unless `ready_o`=1.
- empty  input  1  sampled with `start`; 1 = zero-length message, no stream bytes follow
- key  input  128  sampled on accepted `start`; k0=key[63:0], k1=key[127:64]
- s_valid  input  1  message byte valid
- s_data  input  8  message byte
- s_last  input  1  final byte of message (qualified by `s_valid`)
- s_ready  output  1  byte accepted when `s_valid` && `s_ready`
- core_we  output  1  to core `we`
- core_cmd  output  68  to core `cmd`; [67:64] opcode, [63:0] data
- core_busy  input  1  from core `busy`
- core_result  input  64  from core `result`
- ready_o  output  1  idle, can accept `start`
- hash_valid  output  1  one-cycle pulse
- hash  output  64  valid with `hash_valid`; held until the next result

Behaviour:
- Reset (async, rst_n=0) values:
  - All outputs 0, except `ready_o`=1.
  - FSM enters IDLE; word buffer and byte counter cleared.
  - Reset mid-hash aborts with no `hash_valid`.
- Opcodes: 0000 key k0, 0001 key k1, 0010 compress, 0011 finalize.
- Core handshake:
  - Issue a command only when `core_busy`=0.
  - `core_we` is high for exactly one cycle per command.
  - `core_cmd` is held stable from the issue cycle until the cycle `core_busy` is seen low again. The core re-reads cmd data at round end.
  - After a compress/finalize issue, `core_busy` is 1 from the next cycle. WAIT states exit on the first cycle with `core_busy`=0.
- FSM:
  - IDLE: `ready_o`=1, `s_ready`=0. On `start`: latch key, clear counter and buffer, go to KEY0.
  - KEY0: issue {0000,k0}; go to KEY1.
  - KEY1: issue {0001,k1}; go to PAD if `empty`, else COLLECT.
  - COLLECT: `s_ready`=1.
    - Each accepted byte goes to buffer byte lane (cnt mod 8), little-endian: first byte in bits [7:0]. Counter increments.
    - On the 8th byte of a word: go to COMP. Applies even if `s_last`; record last-seen.
    - On `s_last` with fewer than 8 bytes in the buffer: go to PAD.
  - COMP: `s_ready`=0. Issue {0010,buffer}; go to CWAIT.
  - CWAIT: hold cmd. When busy=0: clear buffer, then go to PAD if last-seen, else COLLECT.
  - PAD: issue {0010, (cnt[7:0]<<56) | buffer}. Buffer holds the 0–7 trailing bytes; unused lanes are 0. Go to PWAIT.
  - PWAIT: hold cmd; when busy=0, go to FIN.
  - FIN: issue {0011, 64'h0}; go to FWAIT.
  - FWAIT: when busy=0, go to DONE.
  - DONE: `hash` <= `core_result`, `hash_valid`=1 for one cycle; go to IDLE.
- Edge cases:
  - Message length a multiple of 8: PAD data is exactly len<<56.
  - Counter wraps at 2^CNT_W; the length byte is the true length mod 256 when CNT_W≥8.
  - `start` outside IDLE is ignored.
  - `s_valid` outside COLLECT is not accepted (`s_ready`=0).
  - Bytes after `s_last` are not consumed until the next hash.
- Latency: per word, 8 byte cycles plus the core round time plus 2 cycles. `hash_valid` follows the core's finalize completion by 1 cycle.

Test Plan:
- Key 0x0f0e…0100 (bytes 00..0f), `start` with `empty`=1 -> cmd sequence 0000,0001, pad word 0x0000000000000000, 0011; `hash`=0x726fdb47dd0e0e31.
- Same key, message {00} -> pad word 0x0100000000000000; `hash`=0x74f839c593dc67fd.
- Same key, message 00..07 (`s_last` on 8th byte) -> one compress 0x0706050403020100, pad word 0x0800000000000000; `hash`=0x93f5f5799a932462.
- Same key, message 00..0e -> compress 0x0706050403020100, pad 0x0f0e0d0c0b0a0908; `hash`=0xa129ca6149be45e5.
- Throttled `s_valid` (random gaps), plus `start` asserted mid-hash -> `core_we` never high while `core_busy`=1; `core_cmd` stable through every busy window; extra `start` ignored; same hashes as above.
- `rst_n` low during CWAIT -> all outputs 0 immediately (async), `ready_o`=1 after release, no `hash_valid`. A following empty-message hash returns 0x726fdb47dd0e0e31.
